// File: rtl/cmd_scheduler_pkg.sv
// Shared definitions for the command scheduler and everything that talks to it:
// the layout of the 80-bit command word, the scheduler state encoding and the
// opcodes understood by the destination units and the host software.
package cmd_scheduler_pkg;

  // Command word layout: [79:72] dest, [71:64] opcode, [63:32] start_time, [31:0] payload
  localparam int CMD_DEST_LSB = 72;
  localparam int CMD_DEST_W   = 8;
  localparam int CMD_OP_LSB   = 64;
  localparam int CMD_OP_W     = 8;
  localparam int CMD_TIME_LSB = 32;
  localparam int CMD_TIME_W   = 32;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_DATA_W   = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LATCH = 3'd2,
    S_WAIT  = 3'd3,
    S_ISSUE = 3'd4,
    S_DROP  = 3'd5
  } sched_state_t;

  // Opcodes shared with destination units and the host header
  localparam logic [CMD_OP_W-1:0] OP_NOP       = 8'h00;
  localparam logic [CMD_OP_W-1:0] OP_PIN_SET   = 8'h01;
  localparam logic [CMD_OP_W-1:0] OP_DAC_SET   = 8'h02;
  localparam logic [CMD_OP_W-1:0] OP_SAMPLE_GO = 8'h03;

  // Pack the fields of one command into the FIFO word format
  function automatic logic [79:0] make_cmd(input logic [CMD_DEST_W-1:0] dest,
                                           input logic [CMD_OP_W-1:0]   op,
                                           input logic [CMD_TIME_W-1:0] start,
                                           input logic [CMD_DATA_W-1:0] data);
    return {dest, op, start, data};
  endfunction

endpackage

// File: rtl/cmd_scheduler_if.sv
// Shared addressed command bus between the scheduler (master) and the
// destination units (slave).
//   bus_dest/op/data : command fields, stable while bus_valid=1
//   bus_valid        : command present
//   dest_ready       : one ready per destination; the handshake uses dest_ready[bus_dest]
interface cmd_scheduler_if
  import cmd_scheduler_pkg::*;
#(
  parameter int NUM_DEST = 16
) ();
  logic [CMD_DEST_W-1:0] bus_dest;
  logic [CMD_OP_W-1:0]   bus_op;
  logic [CMD_DATA_W-1:0] bus_data;
  logic                  bus_valid;
  logic [NUM_DEST-1:0]   dest_ready;

  modport master (output bus_dest, bus_op, bus_data, bus_valid, input dest_ready);
  modport slave  (input bus_dest, bus_op, bus_data, bus_valid, output dest_ready);
endinterface

// File: rtl/cmd_scheduler.sv
// Command scheduler: drains the command FIFO one entry at a time and releases
// each command onto the shared command bus once global_clock reaches its start
// time. Exactly one command is held at a time.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_sched_en         allow popping the FIFO (an in-flight command always completes)
//   i_global_clock     time base compared against the command start time
//   i_cmd_fifo_dout    FIFO read data, valid the cycle after o_cmd_fifo_rd_en
//   i_cmd_fifo_empty   FIFO empty flag
//   o_cmd_fifo_rd_en   one-cycle FIFO pop
//   bus                command bus (master side)
//   o_busy             scheduler not idle
//   o_late_cnt         commands released after their start time (saturating)
//   o_bad_dest_cnt     commands dropped for an out-of-range destination (saturating)
//   o_issued_cnt       commands accepted by a destination (wrapping)
module cmd_scheduler
  import cmd_scheduler_pkg::*;
#(
  parameter int NUM_DEST = 16,
  parameter int CMD_W    = 80,
  parameter int TIME_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sched_en,
  input  logic [TIME_W-1:0]  i_global_clock,
  input  logic [CMD_W-1:0]   i_cmd_fifo_dout,
  input  logic               i_cmd_fifo_empty,
  output logic               o_cmd_fifo_rd_en,
  cmd_scheduler_if.master    bus,
  output logic               o_busy,
  output logic [15:0]        o_late_cnt,
  output logic [15:0]        o_bad_dest_cnt,
  output logic [31:0]        o_issued_cnt
);

  localparam int DIDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  sched_state_t          r_state;
  logic                  r_rd_en;
  logic                  r_valid;
  logic                  r_first_wait;
  logic [CMD_DEST_W-1:0] r_dest;
  logic [CMD_OP_W-1:0]   r_op;
  logic [TIME_W-1:0]     r_start;
  logic [CMD_DATA_W-1:0] r_data;
  logic [15:0]           r_late_cnt;
  logic [15:0]           r_bad_cnt;
  logic [31:0]           r_issued_cnt;

  logic [CMD_DEST_W-1:0] w_fifo_dest;
  logic                  w_bad_dest;
  logic [TIME_W-1:0]     w_diff;
  logic                  w_due;
  logic [DIDX_W-1:0]     w_dest_idx;
  logic                  w_dest_rdy;

  assign w_fifo_dest = i_cmd_fifo_dout[CMD_DEST_LSB +: CMD_DEST_W];
  assign w_bad_dest  = (int'(w_fifo_dest) >= NUM_DEST);

  // Wrap-safe due test: the start time counts as reached when it lies within
  // the half-range window behind global_clock.
  assign w_diff = i_global_clock - r_start;
  assign w_due  = ~w_diff[TIME_W-1];

  // Only consulted in ISSUE, where r_dest is known to be in range
  assign w_dest_idx = r_dest[DIDX_W-1:0];
  assign w_dest_rdy = bus.dest_ready[w_dest_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_en      <= 1'b0;
      r_valid      <= 1'b0;
      r_first_wait <= 1'b0;
      r_dest       <= '0;
      r_op         <= '0;
      r_start      <= '0;
      r_data       <= '0;
      r_late_cnt   <= '0;
      r_bad_cnt    <= '0;
      r_issued_cnt <= '0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_sched_en && !i_cmd_fifo_empty) begin
            r_state <= S_POP;
            r_rd_en <= 1'b1;
          end
        end
        // rd_en is high during this cycle; data arrives in LATCH
        S_POP: r_state <= S_LATCH;
        S_LATCH: begin
          r_dest       <= w_fifo_dest;
          r_op         <= i_cmd_fifo_dout[CMD_OP_LSB +: CMD_OP_W];
          r_start      <= i_cmd_fifo_dout[CMD_TIME_LSB +: TIME_W];
          r_data       <= i_cmd_fifo_dout[CMD_DATA_LSB +: CMD_DATA_W];
          r_first_wait <= 1'b1;
          r_state      <= w_bad_dest ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          r_first_wait <= 1'b0;
          if (w_due) begin
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
            // Already past its start time when it arrived (exact hit is on time)
            if (r_first_wait && (i_global_clock != r_start) && (r_late_cnt != 16'hFFFF))
              r_late_cnt <= r_late_cnt + 16'd1;
          end
        end
        S_ISSUE: begin
          if (w_dest_rdy) begin
            r_valid      <= 1'b0;
            r_issued_cnt <= r_issued_cnt + 32'd1;
            r_state      <= S_IDLE;
          end
        end
        S_DROP: begin
          if (r_bad_cnt != 16'hFFFF) r_bad_cnt <= r_bad_cnt + 16'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_fifo_rd_en = r_rd_en;
  assign o_busy           = (r_state != S_IDLE);
  assign o_late_cnt       = r_late_cnt;
  assign o_bad_dest_cnt   = r_bad_cnt;
  assign o_issued_cnt     = r_issued_cnt;

  assign bus.bus_valid = r_valid;
  assign bus.bus_dest  = r_dest;
  assign bus.bus_op    = r_op;
  assign bus.bus_data  = r_data;

endmodule

// File: tb/tb_cmd_scheduler.sv
module tb_cmd_scheduler;
  import cmd_scheduler_pkg::*;

  localparam int ND = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic [31:0] gc;
  logic [79:0] fifo_dout;
  logic        fifo_empty;
  logic        rd_en;
  logic        busy;
  logic [15:0] late_cnt, bad_cnt;
  logic [31:0] issued_cnt;

  cmd_scheduler_if #(.NUM_DEST(ND)) bus_if ();

  cmd_scheduler #(.NUM_DEST(ND), .CMD_W(80), .TIME_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_sched_en       (sched_en),
    .i_global_clock   (gc),
    .i_cmd_fifo_dout  (fifo_dout),
    .i_cmd_fifo_empty (fifo_empty),
    .o_cmd_fifo_rd_en (rd_en),
    .bus              (bus_if.master),
    .o_busy           (busy),
    .o_late_cnt       (late_cnt),
    .o_bad_dest_cnt   (bad_cnt),
    .o_issued_cnt     (issued_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop
  logic [79:0] fifo_mem [0:63];
  logic [6:0]  wr_ptr = '0;
  logic [6:0]  rd_ptr = '0;
  logic        pop_empty = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      if (wr_ptr == rd_ptr) pop_empty <= 1'b1;
      fifo_dout <= fifo_mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 7'd1;
    end
  end

  int errs = 0;
  int checks = 0;
  int exp_late = 0, exp_bad = 0, exp_issued = 0;

  logic        s_valid, s_rd_en, s_busy;
  logic [7:0]  s_dest, s_op;
  logic [31:0] s_data, s_gc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, snapshot outputs at the falling edge, then tick the time base
  task automatic cyc();
    @(negedge clk);
    s_valid = bus_if.bus_valid;
    s_dest  = bus_if.bus_dest;
    s_op    = bus_if.bus_op;
    s_data  = bus_if.bus_data;
    s_rd_en = rd_en;
    s_busy  = busy;
    s_gc    = gc;
    gc      = gc + 32'd1;
  endtask

  task automatic push(input logic [7:0] dest, input logic [7:0] op,
                      input logic [31:0] start, input logic [31:0] data);
    fifo_mem[wr_ptr[5:0]] = make_cmd(dest, op, start, data);
    wr_ptr = wr_ptr + 7'd1;
  endtask

  // Wait for the command on the bus, hold ready low for 'delay' cycles of valid,
  // and check timing, field stability and counters.
  task automatic expect_issue(input logic [7:0] dest, input logic [7:0] op,
                              input logic [31:0] start, input logic [31:0] data,
                              input int delay, input bit late, input bit chk_lat);
    int n = 0;
    int held = 1;
    bit seen = 1'b0;
    bus_if.dest_ready = 16'($urandom) & ~(16'd1 << dest[3:0]);
    while (!seen && n < 300) begin
      cyc();
      n++;
      seen = s_valid;
    end
    chk("valid_rise", 64'(seen), 64'd1);
    if (!seen) return;
    if (chk_lat) chk("latency", 64'(n), 64'd4);
    if (!late) chk("rise_gc", 64'(s_gc), 64'(start));
    if (late) exp_late++;
    chk("late_cnt", 64'(late_cnt), 64'(exp_late));
    while (held < 40) begin
      chk("bus_fields", 64'({s_dest, s_op, s_data}), 64'({dest, op, data}));
      if (held == delay + 1) bus_if.dest_ready[dest[3:0]] = 1'b1;
      cyc();
      if (!s_valid) break;
      held++;
    end
    chk("valid_hold", 64'(held), 64'(delay + 1));
    bus_if.dest_ready = '0;
    exp_issued++;
    chk("issued_cnt", 64'(issued_cnt), 64'(exp_issued));
    chk("busy_idle", 64'(s_busy), 64'd0);
  endtask

  task automatic expect_drop();
    bit seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (s_valid) seen = 1'b1;
    end
    chk("drop_no_valid", 64'(seen), 64'd0);
    exp_bad++;
    chk("bad_dest_cnt", 64'(bad_cnt), 64'(exp_bad));
    chk("issued_after_drop", 64'(issued_cnt), 64'(exp_issued));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d, o;
    logic [31:0] st, dt;
    bit          past;
    int          dly;
    logic [6:0]  rd_save;
    bit          seen;

    rst = 1'b1; sched_en = 1'b1; gc = '0; bus_if.dest_ready = '0;
    repeat (3) cyc();
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_rd_en", 64'(s_rd_en), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_bus", 64'({s_dest, s_op, s_data}), 64'd0);
    chk("rst_cnts", 64'({late_cnt, bad_cnt, issued_cnt}), 64'd0);
    rst = 1'b0;
    cyc();

    // 1: future start, sched_en dropped mid-flight must not abort it
    gc = 32'd50;
    push(8'd3, OP_PIN_SET, 32'd100, 32'hCAFEF00D);
    cyc(); cyc();
    sched_en = 1'b0;
    expect_issue(8'd3, OP_PIN_SET, 32'd100, 32'hCAFEF00D, 0, 1'b0, 1'b0);
    sched_en = 1'b1;

    // 2: start time long past -> issued without waiting, counted late
    gc = 32'd500;
    push(8'd7, OP_DAC_SET, 32'd10, 32'h12345678);
    expect_issue(8'd7, OP_DAC_SET, 32'd10, 32'h12345678, 2, 1'b1, 1'b1);

    // 3: bad destination dropped, next entry handled normally
    push(8'd20, OP_NOP, gc, 32'hDEAD0000);
    push(8'd2, OP_SAMPLE_GO, gc - 32'd5, 32'h0BADBEEF);
    expect_drop();
    expect_issue(8'd2, OP_SAMPLE_GO, gc, 32'h0BADBEEF, 0, 1'b1, 1'b0);

    // 4: destination stalls 7 cycles
    st = gc + 32'd30;
    push(8'd5, OP_DAC_SET, st, 32'hA5A5A5A5);
    expect_issue(8'd5, OP_DAC_SET, st, 32'hA5A5A5A5, 7, 1'b0, 1'b0);

    // 5: wait across time-base wrap
    gc = 32'hFFFFFFF0;
    push(8'd9, OP_PIN_SET, 32'h00000005, 32'h00C0FFEE);
    expect_issue(8'd9, OP_PIN_SET, 32'h00000005, 32'h00C0FFEE, 1, 1'b0, 1'b0);

    // Randomized commands, one at a time from idle
    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom_range(0, 19));
      o    = 8'($urandom);
      dt   = $urandom;
      past = 1'($urandom_range(0, 1));
      dly  = $urandom_range(0, 3);
      st   = past ? gc - 32'd1 - 32'($urandom_range(0, 1000))
                  : gc + 32'd20 + 32'($urandom_range(0, 30));
      push(d, o, st, dt);
      if (d >= 8'd16) expect_drop();
      else            expect_issue(d, o, st, dt, dly, past, past);
    end

    // 6: sched_en low holds queued work; reset during ISSUE discards the held command
    sched_en = 1'b0;
    rd_save = rd_ptr;
    push(8'd1, OP_PIN_SET, gc - 32'd100, 32'h11111111);
    push(8'd2, OP_PIN_SET, gc - 32'd100, 32'h22222222);
    push(8'd3, OP_PIN_SET, gc - 32'd100, 32'h33333333);
    repeat (10) cyc();
    chk("hold_no_pop", 64'(rd_ptr), 64'(rd_save));
    chk("hold_busy", 64'(s_busy), 64'd0);
    sched_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      seen = s_valid;
    end
    chk("pre_rst_valid", 64'(seen), 64'd1);
    rst = 1'b1;
    cyc();
    chk("midrst_valid", 64'(s_valid), 64'd0);
    chk("midrst_busy", 64'(s_busy), 64'd0);
    chk("midrst_cnts", 64'({late_cnt, bad_cnt, issued_cnt}), 64'd0);
    exp_late = 0; exp_bad = 0; exp_issued = 0;
    rst = 1'b0;
    expect_issue(8'd2, OP_PIN_SET, gc, 32'h22222222, 0, 1'b1, 1'b0);
    expect_issue(8'd3, OP_PIN_SET, gc, 32'h33333333, 1, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("all_popped", 64'(rd_ptr), 64'(wr_ptr));
    chk("no_pop_empty", 64'(pop_empty), 64'd0);
    chk("final_busy", 64'(s_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
